// File: rtl/lookup_sched_pkg.sv
// Shared types and constants for the flow-lookup scheduler: key/sequence/time/id widths,
// the buffered input entry, the in-flight tracker entry and a saturating counter helper.
package lookup_sched_pkg;

    localparam int TUPLE_W = 96;
    localparam int SQN_W   = 32;
    localparam int TIME_W  = 32;
    localparam int ID_W    = 16;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [TUPLE_W-1:0] tuple;
        logic [SQN_W-1:0]   sqn;
        logic [TIME_W-1:0]  ts;
    } entry_t;

    typedef struct packed {
        logic               port;
        logic [SQN_W-1:0]   sqn;
        logic [TIME_W-1:0]  ts;
    } track_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int TRACK_W = $bits(track_t);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; writes into a full FIFO and reads from an
// empty FIFO are ignored. DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/lookup_sched.sv
// Timestamps egress/ingress parser results, arbitrates them round-robin onto the shared
// flow-lookup engine and routes in-order lookup results back to the originating port.
module lookup_sched
    import lookup_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid_0,
    input  logic [TUPLE_W-1:0] in_tuple_0,
    input  logic [SQN_W-1:0]   in_sqn_0,
    input  logic               in_valid_1,
    input  logic [TUPLE_W-1:0] in_tuple_1,
    input  logic [SQN_W-1:0]   in_sqn_1,
    input  logic               in_search_ready,
    output logic               out_valid_search,
    output logic [TUPLE_W-1:0] out_search_key,
    input  logic               in_valid_result,
    input  logic               in_result_hit,
    input  logic [ID_W-1:0]    in_result_id,
    output logic               out_valid_0,
    output logic [ID_W-1:0]    out_id_0,
    output logic [TIME_W-1:0]  out_time_0,
    output logic [SQN_W-1:0]   out_sqn_0,
    output logic               out_valid_1,
    output logic [ID_W-1:0]    out_id_1,
    output logic [TIME_W-1:0]  out_time_1,
    output logic [SQN_W-1:0]   out_sqn_1,
    output logic [CNT_W-1:0]   out_drop_cnt_0,
    output logic [CNT_W-1:0]   out_drop_cnt_1,
    output logic [CNT_W-1:0]   out_miss_cnt,
    output logic               out_err
);

    logic [TIME_W-1:0] time_cnt;
    entry_t            wr_entry_0, wr_entry_1, head_0, head_1, gnt_entry;
    track_t            trk_wr, trk_head;
    logic              full_0, full_1, empty_0, empty_1, trk_full, trk_empty;
    logic              grant, grant_port, last_grant, res_pop, hit_0, hit_1;
    logic [$clog2(FIFO_DEPTH):0] cnt_0_unused, cnt_1_unused;
    logic [$clog2(MAX_OUT):0]    trk_cnt_unused;

    assign wr_entry_0 = '{tuple: in_tuple_0, sqn: in_sqn_0, ts: time_cnt};
    assign wr_entry_1 = '{tuple: in_tuple_1, sqn: in_sqn_1, ts: time_cnt};

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
        .clk(clk), .reset(reset),
        .wr_en(in_valid_0), .wr_data(wr_entry_0),
        .rd_en(grant && !grant_port), .rd_data(head_0),
        .full(full_0), .empty(empty_0), .count(cnt_0_unused)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
        .clk(clk), .reset(reset),
        .wr_en(in_valid_1), .wr_data(wr_entry_1),
        .rd_en(grant && grant_port), .rd_data(head_1),
        .full(full_1), .empty(empty_1), .count(cnt_1_unused)
    );

    // Grant: alternate when both ports wait, otherwise serve whichever is non-empty.
    always_comb begin
        grant      = in_search_ready && !trk_full && !(empty_0 && empty_1);
        grant_port = (!empty_0 && !empty_1) ? ~last_grant : empty_0;
        gnt_entry  = grant_port ? head_1 : head_0;
        trk_wr     = '{port: grant_port, sqn: gnt_entry.sqn, ts: gnt_entry.ts};
    end

    assign res_pop = in_valid_result && !trk_empty;
    assign hit_0   = res_pop && in_result_hit && !trk_head.port;
    assign hit_1   = res_pop && in_result_hit &&  trk_head.port;

    // Tracker full is sampled before this cycle's pop, so a pop never opens a slot early.
    sync_fifo #(.WIDTH(TRACK_W), .DEPTH(MAX_OUT)) u_tracker (
        .clk(clk), .reset(reset),
        .wr_en(grant), .wr_data(trk_wr),
        .rd_en(res_pop), .rd_data(trk_head),
        .full(trk_full), .empty(trk_empty), .count(trk_cnt_unused)
    );

    // Issue stage and bookkeeping counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            time_cnt         <= '0;
            last_grant       <= 1'b1;
            out_valid_search <= 1'b0;
            out_search_key   <= '0;
            out_drop_cnt_0   <= '0;
            out_drop_cnt_1   <= '0;
            out_miss_cnt     <= '0;
            out_err          <= 1'b0;
        end else begin
            time_cnt         <= time_cnt + 1'b1;
            out_valid_search <= grant;
            if (grant) begin
                last_grant     <= grant_port;
                out_search_key <= gnt_entry.tuple;
            end
            if (in_valid_0 && full_0) out_drop_cnt_0 <= sat_inc(out_drop_cnt_0);
            if (in_valid_1 && full_1) out_drop_cnt_1 <= sat_inc(out_drop_cnt_1);
            if (res_pop && !in_result_hit) out_miss_cnt <= sat_inc(out_miss_cnt);
            if (in_valid_result && trk_empty) out_err <= 1'b1;
        end
    end

    // Result stage: one-cycle pulse on the originating port, data held between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_0 <= 1'b0;
            out_id_0    <= '0;
            out_time_0  <= '0;
            out_sqn_0   <= '0;
            out_valid_1 <= 1'b0;
            out_id_1    <= '0;
            out_time_1  <= '0;
            out_sqn_1   <= '0;
        end else begin
            out_valid_0 <= hit_0;
            out_valid_1 <= hit_1;
            if (hit_0) begin
                out_id_0   <= in_result_id;
                out_time_0 <= trk_head.ts;
                out_sqn_0  <= trk_head.sqn;
            end
            if (hit_1) begin
                out_id_1   <= in_result_id;
                out_time_1 <= trk_head.ts;
                out_sqn_1  <= trk_head.sqn;
            end
        end
    end

endmodule

// File: tb/tb_lookup_sched.sv
// Scoreboard bench for lookup_sched: stimulus pushes expected search keys and port results,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_lookup_sched;
    import lookup_sched_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid_0 = 1'b0, in_valid_1 = 1'b0;
    logic [TUPLE_W-1:0] in_tuple_0 = '0, in_tuple_1 = '0;
    logic [SQN_W-1:0]   in_sqn_0 = '0, in_sqn_1 = '0;
    logic               in_search_ready = 1'b0;
    logic               out_valid_search;
    logic [TUPLE_W-1:0] out_search_key;
    logic               in_valid_result = 1'b0, in_result_hit = 1'b0;
    logic [ID_W-1:0]    in_result_id = '0;
    logic               out_valid_0, out_valid_1;
    logic [ID_W-1:0]    out_id_0, out_id_1;
    logic [TIME_W-1:0]  out_time_0, out_time_1;
    logic [SQN_W-1:0]   out_sqn_0, out_sqn_1;
    logic [CNT_W-1:0]   out_drop_cnt_0, out_drop_cnt_1, out_miss_cnt;
    logic               out_err;

    always #5 clk = ~clk;

    lookup_sched #(.FIFO_DEPTH(4), .MAX_OUT(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid_0(in_valid_0), .in_tuple_0(in_tuple_0), .in_sqn_0(in_sqn_0),
        .in_valid_1(in_valid_1), .in_tuple_1(in_tuple_1), .in_sqn_1(in_sqn_1),
        .in_search_ready(in_search_ready),
        .out_valid_search(out_valid_search), .out_search_key(out_search_key),
        .in_valid_result(in_valid_result), .in_result_hit(in_result_hit),
        .in_result_id(in_result_id),
        .out_valid_0(out_valid_0), .out_id_0(out_id_0), .out_time_0(out_time_0),
        .out_sqn_0(out_sqn_0),
        .out_valid_1(out_valid_1), .out_id_1(out_id_1), .out_time_1(out_time_1),
        .out_sqn_1(out_sqn_1),
        .out_drop_cnt_0(out_drop_cnt_0), .out_drop_cnt_1(out_drop_cnt_1),
        .out_miss_cnt(out_miss_cnt), .out_err(out_err)
    );

    typedef struct {
        bit          port;
        logic [15:0] id;
        logic [31:0] ts;
        logic [31:0] sqn;
    } exp_out_t;

    exp_out_t           exp_out_q[$];
    logic [TUPLE_W-1:0] exp_key_q[$];
    int                 n_cmp = 0;
    int                 n_err = 0;
    int                 search_cnt = 0;
    logic [31:0]        tcnt;

    // Reference time: cycles elapsed since reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) tcnt <= '0;
        else       tcnt <= tcnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input bit port, input logic [15:0] id, input logic [31:0] ts,
                             input logic [31:0] sqn);
        exp_out_t e;
        if (exp_out_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_unexpected: port %0d pulsed with id %0h, none expected", port, id);
        end else begin
            e = exp_out_q.pop_front();
            check("out_port", 128'(port), 128'(e.port));
            check("out_id", 128'(id), 128'(e.id));
            check("out_time", 128'(ts), 128'(e.ts));
            check("out_sqn", 128'(sqn), 128'(e.sqn));
        end
    endtask

    // Monitor
    initial begin
        logic [TUPLE_W-1:0] k;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (out_valid_search) begin
                    search_cnt++;
                    if (exp_key_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL search_unexpected: key %0h, none expected", out_search_key);
                    end else begin
                        k = exp_key_q.pop_front();
                        check("search_key", 128'(out_search_key), 128'(k));
                    end
                end
                if (out_valid_0) check_out(1'b0, out_id_0, out_time_0, out_sqn_0);
                if (out_valid_1) check_out(1'b1, out_id_1, out_time_1, out_sqn_1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
        in_valid_result = 1'b0;
        exp_out_q.delete();
        exp_key_q.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic strobe(input bit v0, input logic [TUPLE_W-1:0] k0, input logic [31:0] s0,
                          input bit v1, input logic [TUPLE_W-1:0] k1, input logic [31:0] s1,
                          output logic [31:0] ts);
        in_valid_0 = v0; in_tuple_0 = k0; in_sqn_0 = s0;
        in_valid_1 = v1; in_tuple_1 = k1; in_sqn_1 = s1;
        ts = tcnt;
        tick(1);
        in_valid_0 = 1'b0;
        in_valid_1 = 1'b0;
    endtask

    task automatic result(input bit hit, input logic [15:0] id);
        in_valid_result = 1'b1;
        in_result_hit = hit;
        in_result_id = id;
        tick(1);
        in_valid_result = 1'b0;
    endtask

    initial begin
        logic [31:0]        ta0, ta1, ts_tmp;
        logic [31:0]        tsd[9];
        logic [TUPLE_W-1:0] key;
        int                 base;

        // Reset state and single egress lookup
        do_reset();
        in_search_ready = 1'b1;
        check("rst_valid_search", 128'(out_valid_search), 128'(0));
        check("rst_valid_0", 128'(out_valid_0), 128'(0));
        check("rst_drop_1", 128'(out_drop_cnt_1), 128'(0));
        check("rst_miss", 128'(out_miss_cnt), 128'(0));
        check("rst_err", 128'(out_err), 128'(0));
        for (int i = 0; i < 20 && tcnt != 5; i++) tick(1);
        exp_key_q.push_back(96'haaaa1111);
        strobe(1'b1, 96'haaaa1111, 32'hbbbb1111, 1'b0, '0, '0, ts_tmp);
        tick(2);
        exp_out_q.push_back('{port: 1'b0, id: 16'h0011, ts: 32'd5, sqn: 32'hbbbb1111});
        result(1'b1, 16'h0011);
        tick(2);

        // Both ports loaded: grants alternate 0,1,0,1 and results route back
        do_reset();
        in_search_ready = 1'b0;
        strobe(1'b1, 96'ha0, 32'h10, 1'b1, 96'hb0, 32'h20, ta0);
        strobe(1'b1, 96'ha1, 32'h11, 1'b1, 96'hb1, 32'h21, ta1);
        exp_key_q.push_back(96'ha0);
        exp_key_q.push_back(96'hb0);
        exp_key_q.push_back(96'ha1);
        exp_key_q.push_back(96'hb1);
        base = search_cnt;
        in_search_ready = 1'b1;
        tick(6);
        check("rr_search_cnt", 128'(search_cnt - base), 128'(4));
        exp_out_q.push_back('{port: 1'b0, id: 16'h1, ts: ta0, sqn: 32'h10});
        exp_out_q.push_back('{port: 1'b1, id: 16'h2, ts: ta0, sqn: 32'h20});
        exp_out_q.push_back('{port: 1'b0, id: 16'h3, ts: ta1, sqn: 32'h11});
        exp_out_q.push_back('{port: 1'b1, id: 16'h4, ts: ta1, sqn: 32'h21});
        for (int i = 1; i <= 4; i++) result(1'b1, 16'(i));
        tick(2);

        // Overflow: 6 strobes into a 4-deep FIFO
        do_reset();
        in_search_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key = 96'hc0 + 96'(i);
            if (i < 4) exp_key_q.push_back(key);
            strobe(1'b0, '0, '0, 1'b1, key, 32'(i), ts_tmp);
        end
        tick(1);
        check("ovf_drop_1", 128'(out_drop_cnt_1), 128'(2));
        check("ovf_drop_0", 128'(out_drop_cnt_0), 128'(0));
        base = search_cnt;
        in_search_ready = 1'b1;
        tick(8);
        check("ovf_search_cnt", 128'(search_cnt - base), 128'(4));

        // Backpressure: tracker holds 8, the 9th waits for a result
        do_reset();
        in_search_ready = 1'b1;
        base = search_cnt;
        for (int i = 0; i < 9; i++) begin
            key = 96'hd0 + 96'(i);
            exp_key_q.push_back(key);
            strobe(1'b1, key, 32'h100 + 32'(i), 1'b0, '0, '0, tsd[i]);
        end
        tick(6);
        check("bp_search_cnt8", 128'(search_cnt - base), 128'(8));
        exp_out_q.push_back('{port: 1'b0, id: 16'h0100, ts: tsd[0], sqn: 32'h100});
        result(1'b1, 16'h0100);
        check("bp_not_early", 128'(out_valid_search), 128'(0));
        tick(1);
        check("bp_ninth_valid", 128'(out_valid_search), 128'(1));
        check("bp_ninth_key", 128'(out_search_key), 128'(96'hd8));
        tick(1);
        check("bp_search_cnt9", 128'(search_cnt - base), 128'(9));

        // Miss, then spurious result on an empty tracker
        result(1'b0, 16'h0);
        tick(1);
        check("miss_cnt", 128'(out_miss_cnt), 128'(1));
        check("miss_no_err", 128'(out_err), 128'(0));
        do_reset();
        check("rst_clears_miss", 128'(out_miss_cnt), 128'(0));
        result(1'b1, 16'h55);
        tick(1);
        check("err_set", 128'(out_err), 128'(1));
        tick(3);
        check("err_sticky", 128'(out_err), 128'(1));

        // Async reset between edges discards in-flight state
        in_search_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            strobe(i == 0, 96'hf0, 32'h0, 1'b1, 96'he0 + 96'(i), 32'(i), ts_tmp);
        tick(1);
        check("pre_rst_drop_1", 128'(out_drop_cnt_1), 128'(2));
        #2;
        reset = 1'b1;
        #1;
        check("async_drop_1", 128'(out_drop_cnt_1), 128'(0));
        check("async_err", 128'(out_err), 128'(0));
        check("async_valid_search", 128'(out_valid_search), 128'(0));
        exp_out_q.delete();
        exp_key_q.delete();
        tick(1);
        reset = 1'b0;
        in_search_ready = 1'b1;
        base = search_cnt;
        exp_key_q.push_back(96'h9000);
        exp_key_q.push_back(96'h9001);
        strobe(1'b1, 96'h9000, 32'h1, 1'b1, 96'h9001, 32'h2, ts_tmp);
        tick(4);
        check("post_rst_search_cnt", 128'(search_cnt - base), 128'(2));

        tick(3);
        check("keys_drained", 128'(exp_key_q.size()), 128'(0));
        check("outs_drained", 128'(exp_out_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lookup_sched.md
Name: lookup_sched

Overview:
Schedules egress (port 0) and ingress (port 1) parser results onto the single shared flow-lookup engine. Each result is timestamped on arrival, buffered per port, granted round-robin to the search interface, and tracked in order. The lookup response is matched back to its originating port and emitted as (id, time, sqn) toward txrx_ram_update.

Parameters:
FIFO_DEPTH, 4, entries per input FIFO; power of 2, ≥2
MAX_OUT, 8, max outstanding searches; power of 2
TUPLE_W, 96, search key width (4-tuple)
SQN_W, 32, sequence number width
TIME_W, 32, timestamp width
ID_W, 16, flow id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid_0  in  1  egress parser result valid (single-cycle strobe)
in_tuple_0  in  TUPLE_W  egress key
in_sqn_0  in  SQN_W  egress sequence number
in_valid_1  in  1  ingress parser result valid
in_tuple_1  in  TUPLE_W  ingress key
in_sqn_1  in  SQN_W  ingress sequence number
in_search_ready  in  1  lookup engine can accept a key this cycle
out_valid_search  out  1  search request valid
out_search_key  out  TUPLE_W  search key
in_valid_result  in  1  lookup result valid (in request order)
in_result_hit  in  1  key found
in_result_id  in  ID_W  flow id on hit
out_valid_0 / out_valid_1  out  1  per-port result valid
out_id_0 / out_id_1  out  ID_W  flow id
out_time_0 / out_time_1  out  TIME_W  arrival timestamp
out_sqn_0 / out_sqn_1  out  SQN_W  sequence number
out_drop_cnt_0 / out_drop_cnt_1  out  16  input-FIFO overflow drops, saturating
out_miss_cnt  out  16  lookup misses, saturating
out_err  out  1  sticky: result received with nothing outstanding

Behaviour:
- Reset: all outputs 0; FIFOs and tracker empty; time counter 0; last_grant=1 (port 0 wins first).
- Time counter: free-running TIME_W, +1 per cycle, wraps 2^TIME_W-1 -> 0.
- Capture: in_valid_p at edge T writes {tuple, sqn, time_counter@T} into FIFO p. If FIFO p is full, the entry is dropped and drop_cnt_p increments, even if a read occurs in the same cycle. Simultaneous captures on both ports are independent.
- Grant condition: in_search_ready=1, tracker not full (<MAX_OUT), at least one FIFO non-empty.
- Round-robin: both non-empty -> grant port != last_grant; one non-empty -> grant it. last_grant updates on each grant.
- Issue: registered; entry written at edge T shows on out_valid_search earliest at T+1 (1-cycle latency from empty). One grant per cycle max. On grant, pop FIFO, push {port, sqn, time} to tracker.
- out_valid_search held low when no grant; key holds last value (don't care).
- Result: in_valid_result pops tracker head. Hit -> out_valid_<port>=1 next cycle with in_result_id, tracked time/sqn; other port's valid 0. Miss -> no output, miss_cnt++. Tracker empty on result -> ignore, out_err=1 until reset.
- Result pop and grant push in same cycle: both occur; occupancy unchanged; allowed when tracker full (the pop frees a slot only from next cycle; grant blocked that cycle).
- out_valid_p are 1-cycle pulses; data holds between pulses.
- Counters saturate at 0xFFFF.
- Reset mid-operation: all in-flight entries discarded; a later in_valid_result sets out_err.

Decomposition:
- Shared package: TUPLE_W/SQN_W/TIME_W/ID_W constants, entry struct {tuple, sqn, time}, tracker struct {port, sqn, time}.
- One sub-module: sync_fifo (parameterised width/depth, full/empty, count), instantiated twice for inputs and once for the tracker.

Test Plan:
- Single egress: in_valid_0, tuple 'haaaa1111, sqn 'hbbbb1111 at time 5, ready=1 -> search key 'haaaa1111 next cycle; result hit id 'h0011 -> out_valid_0 with id 'h0011, sqn 'hbbbb1111, time 5.
- Simultaneous ports, both FIFOs loaded, ready=1 -> grants 0,1,0,1 alternate; results returned in order route to correct port.
- Overflow: 6 back-to-back port-1 strobes with ready=0, FIFO_DEPTH=4 -> drop_cnt_1=2; after ready=1 exactly 4 searches issued.
- Backpressure: 9 requests, engine never returns -> exactly 8 searches issued; one hit result -> 9th issued the following cycle.
- Miss: result hit=0 -> no out_valid, miss_cnt=1; spurious result with empty tracker -> out_err=1 and stays.
- Async reset asserted mid-stream between edges -> outputs 0 immediately, counters 0, next grant goes to port 0.
